// File: rtl/dct_coeff_quantizer.sv
// ============================================================================
// Module      : dct_coeff_quantizer
// Description : Quantizes Q.9 DCT coefficients with a per-index reciprocal
//               multiplier, rounds half away from zero and saturates to
//               OUT_W bits. Optional statistics counters: DCT_QUANT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_coeff_quantizer #(
   parameter int IN_W  = 24,
   parameter int FRAC  = 9,
   parameter int OUT_W = 7,
   parameter int N_PTS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [IN_W-1:0]            in_data,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   input  logic [8*N_PTS-1:0]         qtab,
   output logic [OUT_W-1:0]           out_data,
   output logic [$clog2(N_PTS)-1:0]   out_idx,
   output logic                       out_last,
   output logic                       out_sat,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       err_align,
   output logic [15:0]                sat_count,
   output logic [15:0]                zero_count
);

   localparam int IDX_W   = $clog2(N_PTS);
   localparam int P_W     = IN_W + 9;
   localparam int C_SHIFT = FRAC + 8;

   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_PTS - 1);
   localparam logic [P_W-1:0]   c_HALF     = {{(P_W-1){1'b0}}, 1'b1} << (C_SHIFT - 1);
   localparam logic [P_W-1:0]   c_POS_MAX  = P_W'(2**(OUT_W-1) - 1);
   localparam logic [P_W-1:0]   c_NEG_MAG  = P_W'(2**(OUT_W-1));

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_RUN  = 1'b1;

   logic [0:0]              r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_idx, w_idx_nxt;
   logic [8*N_PTS-1:0]      r_qtab_sh;
   logic                    r_err_align;

   logic                    w_adv, w_accept, w_at_last, w_blk_start, w_align_err;

   logic                    r_s1_valid;
   logic signed [IN_W-1:0]  r_s1_data;
   logic [IDX_W-1:0]        r_s1_idx;
   logic                    r_s2_valid;
   logic signed [P_W-1:0]   r_s2_prod;
   logic [IDX_W-1:0]        r_s2_idx;

   logic                    r_out_valid, r_out_last, r_out_sat;
   logic [OUT_W-1:0]        r_out_data;
   logic [IDX_W-1:0]        r_out_idx;

   logic signed [8:0]       w_coef;
   logic signed [P_W-1:0]   w_prod;
   logic                    w_neg, w_sat;
   logic [P_W-1:0]          w_abs, w_rnd;
   logic [OUT_W-1:0]        w_q;

   // The whole pipeline freezes only when the output register is full and blocked.
   assign w_adv    = !(r_out_valid && !out_ready);
   assign in_ready = w_adv;
   assign w_accept = in_valid && w_adv;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_idx       <= '0;
         r_qtab_sh   <= '0;
         r_err_align <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept && w_blk_start)
            r_qtab_sh <= qtab;
         if (w_align_err)
            r_err_align <= 1'b1;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (w_accept) begin
         if (w_at_last || in_last) begin
            w_state_nxt = c_ST_IDLE;
            w_idx_nxt   = '0;
         end else begin
            w_state_nxt = c_ST_RUN;
            w_idx_nxt   = r_idx + 1'b1;
         end
      end
   end

   // ---------------- FSM: outputs ----------------
   // RUN never holds index 0, so IDLE alone marks a block start.
   always_comb begin
      w_blk_start = (r_state == c_ST_IDLE);
      w_at_last   = (r_idx == c_IDX_LAST);
      w_align_err = w_accept && (in_last != w_at_last);
   end

   assign w_coef = $signed({1'b0, r_qtab_sh[8*r_s1_idx +: 8]});
   assign w_prod = P_W'(r_s1_data) * P_W'(w_coef);

   // Round half away from zero on the magnitude, then clip to the signed range.
   always_comb begin
      w_neg = r_s2_prod[P_W-1];
      w_abs = w_neg ? -r_s2_prod : r_s2_prod;
      w_rnd = (w_abs + c_HALF) >> C_SHIFT;
      w_sat = 1'b0;
      if (!w_neg && (w_rnd > c_POS_MAX)) begin
         w_q   = {1'b0, {(OUT_W-1){1'b1}}};
         w_sat = 1'b1;
      end else if (w_neg && (w_rnd > c_NEG_MAG)) begin
         w_q   = {1'b1, {(OUT_W-1){1'b0}}};
         w_sat = 1'b1;
      end else begin
         w_q = w_neg ? -w_rnd[OUT_W-1:0] : w_rnd[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_idx    <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_prod   <= '0;
         r_s2_idx    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_out_sat   <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (w_accept) begin
            r_s1_data <= $signed(in_data);
            r_s1_idx  <= r_idx;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_prod <= w_prod;
            r_s2_idx  <= r_s1_idx;
         end
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_out_data <= w_q;
            r_out_idx  <= r_s2_idx;
            r_out_last <= (r_s2_idx == c_IDX_LAST);
            r_out_sat  <= w_sat;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;
   assign out_sat   = r_out_sat;
   assign err_align = r_err_align;

`ifdef DCT_QUANT_STATS_EN
   logic [15:0] r_sat_count, r_zero_count;
   logic        w_out_xfer;

   assign w_out_xfer = r_out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat_count  <= '0;
         r_zero_count <= '0;
      end else if (w_out_xfer) begin
         if (r_out_sat && (r_sat_count != 16'hFFFF))
            r_sat_count <= r_sat_count + 16'd1;
         if ((r_out_data == '0) && (r_zero_count != 16'hFFFF))
            r_zero_count <= r_zero_count + 16'd1;
      end
   end

   assign sat_count  = r_sat_count;
   assign zero_count = r_zero_count;
`else
   assign sat_count  = 16'd0;
   assign zero_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dct_coeff_quantizer.sv
// ============================================================================
// Module      : tb_dct_coeff_quantizer
// Description : Directed self-checking bench for dct_coeff_quantizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_coeff_quantizer;

   localparam int IN_W = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic [23:0]   in_data;
   logic          in_valid, in_last, in_ready;
   logic [31:0]   qtab;
   logic [6:0]    out_data;
   logic [1:0]    out_idx;
   logic          out_last, out_sat, out_valid, out_ready, err_align;
   logic [15:0]   sat_count, zero_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int data;
      int idx;
      int last;
      int sat;
   } obs_t;
   obs_t obs[$];

   dct_coeff_quantizer dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .qtab(qtab),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat),
      .out_valid(out_valid), .out_ready(out_ready),
      .err_align(err_align), .sat_count(sat_count), .zero_count(zero_count)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so negedge values hold through the next edge.
   always @(negedge clk)
      if (!rst && out_valid && out_ready)
         obs.push_back('{int'($signed(out_data)), int'(out_idx), int'(out_last), int'(out_sat)});

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input int d, input bit last);
      bit ok;
      ok       = 1'b0;
      in_data  = d[IN_W-1:0];
      in_valid = 1'b1;
      in_last  = last;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      for (int i = 0; i < 60; i++) begin
         if (obs.size() >= n) break;
         @(negedge clk);
      end
      if (obs.size() < n) check("drain_timeout", obs.size(), n);
      @(posedge clk);
      #1;
   endtask

   task automatic verify(input string tag, input int n, input int ed[8], input int ei[8],
                         input int el[8], input int es[8]);
      check($sformatf("%s_count", tag), obs.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < obs.size()) begin
            check($sformatf("%s_data%0d", tag, i), obs[i].data, ed[i]);
            check($sformatf("%s_idx%0d",  tag, i), obs[i].idx,  ei[i]);
            check($sformatf("%s_last%0d", tag, i), obs[i].last, el[i]);
            check($sformatf("%s_sat%0d",  tag, i), obs[i].sat,  es[i]);
         end
      end
      obs.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] h_data;
      logic [1:0] h_idx;
      int exp_sat, exp_zero;

      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      qtab      = {4{8'd16}};
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data, 0);
      check("rst_idx",   out_idx, 0);
      check("rst_last",  out_last, 0);
      check("rst_sat",   out_sat, 0);
      check("rst_err",   err_align, 0);
      check("rst_ready", in_ready, 1);
      check("rst_satcnt",  sat_count, 0);
      check("rst_zerocnt", zero_count, 0);

      // Basic block with latency probe
      send(51200, 0);
      check("lat_s1_valid", out_valid, 0);
      send(-51200, 0);
      check("lat_s2_valid", out_valid, 0);
      send(4096, 0);
      check("lat_s3_valid", out_valid, 1);
      check("lat_s3_data", int'($signed(out_data)), 6);
      send(-4096, 1);
      wait_outs(4);
      verify("basic", 4, '{6, -6, 1, -1, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0},
             '{0, 0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

      // Saturation at both rails
      qtab = {4{8'd255}};
      send(51200, 0);
      send(-51200, 0);
      send(4096, 0);
      send(0, 1);
      wait_outs(4);
      verify("sat", 4, '{63, -64, 8, 0, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0},
             '{0, 0, 0, 1, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});

      // Backpressure hold in the middle of an 8-coefficient stream
      qtab = {4{8'd16}};
      fork
         begin
            send(51200, 0);  send(-51200, 0); send(4096, 0);   send(-4096, 1);
            send(0, 0);      send(131072, 0); send(-65536, 0); send(6144, 1);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            h_data = out_data;
            h_idx  = out_idx;
            repeat (5) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_valid",    out_valid, 1);
               check("bp_data",     out_data, h_data);
               check("bp_idx",      out_idx, h_idx);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_outs(8);
      verify("bp", 8, '{6, -6, 1, -1, 0, 16, -8, 1}, '{0, 1, 2, 3, 0, 1, 2, 3},
             '{0, 0, 0, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});

`ifdef DCT_QUANT_STATS_EN
      exp_sat  = 2;
      exp_zero = 2;
`else
      exp_sat  = 0;
      exp_zero = 0;
`endif
      check("stat_sat",  sat_count, exp_sat);
      check("stat_zero", zero_count, exp_zero);

      // qtab shadowing: entry 2 changes after the index-0 acceptance
      qtab = {4{8'd16}};
      send(4096, 0);
      qtab[23:16] = 8'd32;
      send(4096, 0);  send(51200, 0); send(4096, 1);
      send(4096, 0);  send(4096, 0);  send(51200, 0); send(4096, 1);
      wait_outs(8);
      verify("shadow", 8, '{1, 1, 6, 1, 1, 1, 13, 1}, '{0, 1, 2, 3, 0, 1, 2, 3},
             '{0, 0, 0, 1, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});

      // Misalignment: early in_last realigns the counter
      qtab = {4{8'd16}};
      check("mis_err_pre", err_align, 0);
      send(51200, 0);
      send(4096, 1);
      check("mis_err_set", err_align, 1);
      send(-4096, 0); send(51200, 0); send(4096, 0); send(-51200, 1);
      wait_outs(6);
      verify("mis", 6, '{6, 1, -1, 6, 1, -6, 0, 0}, '{0, 1, 0, 1, 2, 3, 0, 0},
             '{0, 0, 0, 0, 0, 1, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
      check("mis_err_sticky", err_align, 1);

      // Asynchronous reset with three coefficients in flight
      send(51200, 0);
      send(4096, 0);
      send(-4096, 0);
      rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_data",  out_data, 0);
      check("arst_idx",   out_idx, 0);
      check("arst_last",  out_last, 0);
      check("arst_err",   err_align, 0);
      check("arst_satcnt",  sat_count, 0);
      check("arst_zerocnt", zero_count, 0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      obs.delete();
      repeat (5) @(negedge clk);
      check("arst_no_flush", obs.size(), 0);
      @(posedge clk);
      #1;
      send(51200, 0);
      wait_outs(1);
      verify("post_rst", 1, '{6, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
